// File: rtl/cgra_switch_pkg.sv
// Shared definitions for CGRA switch cells.
//   clog2          : constant ceiling-log2 used to size select fields
//   sel_width      : select field width for a given input count (codes 0..NUM_IN)
//   cfg_width      : config word width (select field plus one reg_mode bit)
//   reg_mode_bit   : bit position of reg_mode inside a config word
//   SEL_LSB        : bit position of the select field LSB
//   cfg_cmd_e      : 2-bit config command used by fabric scan sequences,
//                    bit 0 = shift enable, bit 1 = update
package cgra_switch_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int sel_width(input int num_in);
    return clog2(num_in + 1);
  endfunction

  function automatic int cfg_width(input int num_in);
    return sel_width(num_in) + 1;
  endfunction

  function automatic int reg_mode_bit(input int cfg_w);
    return cfg_w - 1;
  endfunction

  localparam int SEL_LSB = 0;

  typedef enum logic [1:0] {
    CFG_IDLE         = 2'b00,
    CFG_SHIFT        = 2'b01,
    CFG_UPDATE       = 2'b10,
    CFG_SHIFT_UPDATE = 2'b11
  } cfg_cmd_e;

endpackage

// File: rtl/cfg_shadow_chain.sv
// Serial config shift chain with a shadow (active) register.
//   clk        : clock
//   rst_n      : synchronous active-low reset, clears chain and active word
//   shift_in   : serial data in, enters at the LSB
//   shift_en   : shift the chain one position towards the MSB
//   update     : copy the chain into the active word
//   shift_out  : chain MSB, feeds the next cell in the scan path
//   active     : live config word
module cfg_shadow_chain #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_in,
  input  logic             shift_en,
  input  logic             update,
  output logic             shift_out,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] chain;

  // Both registers sample the pre-edge chain, so a simultaneous shift and
  // update loads the word that was complete before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain  <= '0;
      active <= '0;
    end else begin
      if (shift_en) chain  <= {chain[WIDTH-2:0], shift_in};
      if (update)   active <= chain;
    end
  end

  assign shift_out = chain[WIDTH-1];

endmodule

// File: rtl/fullyconn_nx1_reg.sv
// N-input, 1-output CGRA switch cell with scan-loaded routing config.
//   config_clk    : clock for config and data paths
//   config_reset  : synchronous active-low reset
//   config_in     : serial config in
//   config_en     : config chain shift enable
//   config_update : copy chain into the active config
//   config_out    : serial config out (chain MSB)
//   in_bus        : packed inputs, input k = in_bus[k*SIZE +: SIZE]
//   stall         : hold the output register
//   out0          : selected data, combinational or registered per reg_mode
//   cfg_err       : active select code addresses no input
module fullyconn_nx1_reg
  import cgra_switch_pkg::*;
#(
  parameter int NUM_IN = 15,
  parameter int SIZE   = 32
) (
  input  logic                   config_clk,
  input  logic                   config_reset,
  input  logic                   config_in,
  input  logic                   config_en,
  input  logic                   config_update,
  output logic                   config_out,
  input  logic [NUM_IN*SIZE-1:0] in_bus,
  input  logic                   stall,
  output logic [SIZE-1:0]        out0,
  output logic                   cfg_err
);

  localparam int SEL_W        = sel_width(NUM_IN);
  localparam int CFG_W        = cfg_width(NUM_IN);
  localparam int REG_MODE_BIT = reg_mode_bit(CFG_W);

  logic [CFG_W-1:0] active;
  logic [SEL_W-1:0] sel;
  logic             reg_mode;
  logic [SIZE-1:0]  mux_out;
  logic [SIZE-1:0]  out_p1;

  cfg_shadow_chain #(
    .WIDTH(CFG_W)
  ) u_cfg (
    .clk      (config_clk),
    .rst_n    (config_reset),
    .shift_in (config_in),
    .shift_en (config_en),
    .update   (config_update),
    .shift_out(config_out),
    .active   (active)
  );

  assign reg_mode = active[REG_MODE_BIT];
  assign sel      = active[SEL_LSB +: SEL_W];

  // Codes >= NUM_IN match no input and leave the output at zero.
  always_comb begin
    mux_out = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_out = in_bus[k*SIZE +: SIZE];
    end
  end

  assign cfg_err = (sel >= SEL_W'(NUM_IN));

  // Stage p0 -> p1: tracks mux_out in both modes so a switch into
  // registered mode shows an already-valid value.
  always_ff @(posedge config_clk) begin
    if (!config_reset) begin
      out_p1 <= '0;
    end else if (!stall) begin
      out_p1 <= mux_out;
    end
  end

  assign out0 = reg_mode ? out_p1 : mux_out;

endmodule

// File: tb/tb_fullyconn_nx1_reg.sv
module tb_fullyconn_nx1_reg;
  import cgra_switch_pkg::*;

  localparam int NUM_IN = 15;
  localparam int SIZE   = 32;
  localparam int CFG_W  = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cin = 1'b0;
  logic                   en  = 1'b0;
  logic                   upd = 1'b0;
  logic                   stall = 1'b0;
  logic                   cout;
  logic [NUM_IN*SIZE-1:0] in_bus;
  logic [SIZE-1:0]        out0;
  logic                   cfg_err;
  logic [SIZE-1:0]        din [NUM_IN];

  int checks = 0;
  int errors = 0;

  // Reference model state: chain as a bit queue, index 0 = oldest bit = MSB.
  bit          chain_m [$];
  bit          act_m   [$];
  logic [31:0] outq_m;

  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < NUM_IN; k++) in_bus[k*SIZE +: SIZE] = din[k];
  end

  fullyconn_nx1_reg #(.NUM_IN(NUM_IN), .SIZE(SIZE)) dut (
    .config_clk   (clk),
    .config_reset (rst),
    .config_in    (cin),
    .config_en    (en),
    .config_update(upd),
    .config_out   (cout),
    .in_bus       (in_bus),
    .stall        (stall),
    .out0         (out0),
    .cfg_err      (cfg_err)
  );

  function automatic int m_sel();
    int s = 0;
    for (int i = 1; i < CFG_W; i++) s = s * 2 + int'(act_m[i]);
    return s;
  endfunction

  function automatic logic [31:0] m_mux();
    int s = m_sel();
    return (s < NUM_IN) ? din[s] : 32'd0;
  endfunction

  function automatic logic [31:0] m_out();
    return act_m[0] ? outq_m : m_mux();
  endfunction

  task automatic m_clear();
    chain_m.delete();
    act_m.delete();
    for (int i = 0; i < CFG_W; i++) begin
      chain_m.push_back(1'b0);
      act_m.push_back(1'b0);
    end
    outq_m = 32'd0;
  endtask

  task automatic m_edge();
    if (!rst) begin
      m_clear();
    end else begin
      if (!stall) outq_m = m_mux();
      if (upd) act_m = chain_m;
      if (en) begin
        void'(chain_m.pop_front());
        chain_m.push_back(cin);
      end
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out0"}, out0, m_out());
    chk({tag, ".cfg_err"}, {31'd0, cfg_err}, {31'd0, (m_sel() >= NUM_IN)});
    chk({tag, ".config_out"}, {31'd0, cout}, {31'd0, chain_m[0]});
  endtask

  task automatic drive(input cfg_cmd_e cmd, input logic b);
    en  = cmd[0];
    upd = cmd[1];
    cin = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [CFG_W-1:0] w);
    for (int i = CFG_W - 1; i >= 0; i--) begin
      drive(CFG_SHIFT, w[i]);
      tick();
    end
    drive(CFG_UPDATE, 1'b0);
    tick();
    drive(CFG_IDLE, 1'b0);
  endtask

  typedef struct {
    logic [CFG_W-1:0] word;
    logic [31:0]      exp_out;
    logic             exp_err;
  } vec_t;

  vec_t vecs [6];
  logic [9:0] stream;

  initial begin
    for (int k = 0; k < NUM_IN; k++) din[k] = 32'(k);
    din[0] = 32'hA5A5_0000;
    m_clear();

    // Reset
    rst = 1'b0;
    tick();
    chk("reset.out0", out0, 32'hA5A5_0000);
    chk("reset.config_out", {31'd0, cout}, 32'd0);
    chk("reset.cfg_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b1;

    // Route load: route must not change until the update edge
    for (int i = 4; i >= 0; i--) begin
      drive(CFG_SHIFT, (i < 3));
      tick();
      chk("load.hold", out0, 32'hA5A5_0000);
    end
    drive(CFG_UPDATE, 1'b0);
    tick();
    drive(CFG_IDLE, 1'b0);
    chk("load.in7", out0, 32'h0000_0007);
    chk_model("load");

    // Table: combinational-mode routes, including invalid codes
    vecs[0] = '{5'b0_0111, 32'h0000_0007, 1'b0};
    vecs[1] = '{5'b0_1111, 32'h0000_0000, 1'b1};
    vecs[2] = '{5'b0_0000, 32'hA5A5_0000, 1'b0};
    vecs[3] = '{5'b0_1110, 32'h0000_000E, 1'b0};
    vecs[4] = '{5'b0_0001, 32'h0000_0001, 1'b0};
    vecs[5] = '{5'b0_1111, 32'h0000_0000, 1'b1};
    for (int v = 0; v < 6; v++) begin
      load_word(vecs[v].word);
      chk($sformatf("vec%0d.out0", v), out0, vecs[v].exp_out);
      chk($sformatf("vec%0d.cfg_err", v), {31'd0, cfg_err}, {31'd0, vecs[v].exp_err});
    end
    load_word(5'b0_0000);
    chk("reload.cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("reload.out0", out0, 32'hA5A5_0000);

    // Register mode with stall
    din[3] = 32'd1;
    load_word(5'b1_0011);
    chk("reg.first", out0, 32'hA5A5_0000);
    tick();
    chk("reg.in3_1", out0, 32'd1);
    din[3] = 32'd2;
    tick();
    chk("reg.in3_2", out0, 32'd2);
    stall = 1'b1;
    din[3] = 32'd3;
    tick();
    chk("reg.stall1", out0, 32'd2);
    tick();
    chk("reg.stall2", out0, 32'd2);
    stall = 1'b0;
    #1;
    chk("reg.unstall_pre", out0, 32'd2);
    tick();
    chk("reg.unstall", out0, 32'd3);
    chk_model("reg");

    // Chain pass-through with a pause in the middle
    do_reset();
    stream = 10'b1100110101;  // bit 0 is sent first
    for (int i = 0; i < 10; i++) begin
      drive(CFG_SHIFT, stream[i]);
      tick();
      chk($sformatf("pass.shift%0d", i + 1), {31'd0, cout},
          {31'd0, (i >= 4) ? stream[i-4] : 1'b0});
      if (i == 6) begin
        drive(CFG_IDLE, 1'b1);
        for (int p = 0; p < 3; p++) begin
          tick();
          chk($sformatf("pass.pause%0d", p), {31'd0, cout}, {31'd0, stream[2]});
        end
      end
    end
    chk_model("pass");

    // Simultaneous shift+update, then reset part-way through a word
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      drive(CFG_SHIFT, (i == 1));
      tick();
    end
    drive(CFG_SHIFT_UPDATE, 1'b1);
    tick();
    chk("conc.out0", out0, 32'd2);
    chk("conc.config_out", {31'd0, cout}, 32'd0);
    chk_model("conc");
    drive(CFG_SHIFT, 1'b1);
    tick();
    tick();
    drive(CFG_SHIFT_UPDATE, 1'b1);
    stall = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stall = 1'b0;
    chk("rst.out0", out0, 32'hA5A5_0000);
    chk("rst.config_out", {31'd0, cout}, 32'd0);
    chk("rst.cfg_err", {31'd0, cfg_err}, 32'd0);
    drive(CFG_UPDATE, 1'b0);
    tick();
    drive(CFG_IDLE, 1'b0);
    chk("rst.update_cleared", out0, 32'hA5A5_0000);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_IN; k++) din[k] = $urandom;
      rst   = ($urandom_range(0, 59) != 0);
      en    = $urandom_range(0, 1);
      upd   = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      cin   = $urandom_range(0, 1);
      #1;
      chk_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
